rst_seq: RTL and testbench



---
 rtl/rst_seq_if.sv | 27 ++
 rtl/rst_seq.sv | 141 ++++++++++++++
 tb/tb_rst_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// Status/control bundle for the reset release sequencer.
// The slave side is the sequencer; the master side drives lock and soft requests.
interface rst_seq_if #(
  parameter int NUM_STAGES = 4
);
  logic                  lock;
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  seq_done;
  logic [1:0]            seq_state;

  modport master (
    output lock,
    output soft_rst_req,
    input  stage_rst,
    input  seq_done,
    input  seq_state
  );

  modport slave (
    input  lock,
    input  soft_rst_req,
    output stage_rst,
    output seq_done,
    output seq_state
  );
endinterface

// File: rtl/rst_seq.sv
// Reset release sequencer: staged per-domain reset release after lock.
// Optional lock debounce in WAIT_LOCK via RST_SEQ_LOCK_DEBOUNCE_EN.
module rst_seq #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_DLY  = 16,
  parameter int SOFT_HOLD  = 8,
  parameter int LOCK_DEB   = 32
) (
  input  logic      clk,
  input  logic      rst,
  rst_seq_if.slave  sif
);

  localparam int M1 = (STAGE_DLY > SOFT_HOLD) ? STAGE_DLY : SOFT_HOLD;
  localparam int M2 = (M1 > LOCK_DEB) ? M1 : LOCK_DEB;
  localparam int CW = $clog2(M2) + 1;
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] STG_END  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] SOFT_END = CW'(SOFT_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);
`ifdef RST_SEQ_LOCK_DEBOUNCE_EN
  localparam logic [CW-1:0] DEB_END  = CW'(LOCK_DEB - 1);
`endif

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    SOFT      = 2'd3
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [IW-1:0]         idx_q;
  logic [NUM_STAGES-1:0] stage_rst_q;
  logic                  seq_done_q;
  logic [1:0]            lsync_q;
  logic                  lock_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsync_q <= 2'b00;
    end else begin
      lsync_q <= {lsync_q[0], sif.lock};
    end
  end

  assign lock_s = lsync_q[1];

  // Saturating increment; the counter never wraps inside a state.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      seq_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          stage_rst_q <= '1;
          seq_done_q  <= 1'b0;
`ifdef RST_SEQ_LOCK_DEBOUNCE_EN
          if (!lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_END) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
`else
          if (lock_s) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
`endif
        end
        RELEASE, RUN: begin
          // Lock loss takes priority over a coincident soft request.
          if (!lock_s) begin
            state_q     <= WAIT_LOCK;
            stage_rst_q <= '1;
            seq_done_q  <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
          end else if (sif.soft_rst_req) begin
            state_q     <= SOFT;
            stage_rst_q <= '1;
            seq_done_q  <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
          end else if (state_q == RELEASE) begin
            if (cnt_q == STG_END) begin
              // Stages release in index order, so a left shift clears bit idx.
              stage_rst_q <= stage_rst_q << 1;
              cnt_q       <= '0;
              if (idx_q == IDX_LAST) begin
                state_q    <= RUN;
                seq_done_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        SOFT: begin
          stage_rst_q <= '1;
          seq_done_q  <= 1'b0;
          if (cnt_q == SOFT_END) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q     <= WAIT_LOCK;
          stage_rst_q <= '1;
          seq_done_q  <= 1'b0;
          cnt_q       <= '0;
          idx_q       <= '0;
        end
      endcase
    end
  end

  assign sif.stage_rst = stage_rst_q;
  assign sif.seq_done  = seq_done_q;
  assign sif.seq_state = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq at default parameters.
// Edge 0 is the first rising edge after rst is released.
module tb_rst_seq;

  logic clk;
  logic rst;
  int   e;
  int   n_chk;
  int   n_ok;

  rst_seq_if #(.NUM_STAGES(4)) sif ();

  rst_seq #(
    .NUM_STAGES(4),
    .STAGE_DLY (16),
    .SOFT_HOLD (8),
    .LOCK_DEB  (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_ok++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, e);
    end
  endtask

  task automatic goto(input int t);
    if (e < t) begin
      while (e < t) begin
        @(posedge clk);
        e++;
      end
      #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] st,
                         input logic dn, input logic [1:0] ss);
    check({tag, ".stage"}, 32'(sif.stage_rst), 32'(st));
    check({tag, ".done"},  32'(sif.seq_done),  32'(dn));
    check({tag, ".state"}, 32'(sif.seq_state), 32'(ss));
  endtask

  initial begin
    n_chk = 0;
    n_ok  = 0;
    e     = -1;
    rst   = 1'b1;
    sif.lock = 1'b0;
    sif.soft_rst_req = 1'b0;
    #12;
    chk_out("reset", 4'b1111, 1'b0, 2'd0);

    rst = 1'b0;
    sif.lock = 1'b1;
    goto(1);  chk_out("e1",  4'b1111, 1'b0, 2'd0);
    goto(2);  chk_out("e2",  4'b1111, 1'b0, 2'd1);
    goto(17); chk_out("e17", 4'b1111, 1'b0, 2'd1);
    goto(18); chk_out("e18", 4'b1110, 1'b0, 2'd1);
    goto(33); chk_out("e33", 4'b1110, 1'b0, 2'd1);
    goto(34); chk_out("e34", 4'b1100, 1'b0, 2'd1);
    goto(50); chk_out("e50", 4'b1000, 1'b0, 2'd1);
    goto(65); chk_out("e65", 4'b1000, 1'b0, 2'd1);
    goto(66); chk_out("e66", 4'b0000, 1'b1, 2'd2);

    goto(99);  sif.lock = 1'b0;
    goto(101); chk_out("ll101", 4'b0000, 1'b1, 2'd2);
    goto(102); chk_out("ll102", 4'b1111, 1'b0, 2'd0);
    sif.lock = 1'b1;
    goto(104); chk_out("rl104", 4'b1111, 1'b0, 2'd0);
    goto(105); chk_out("rl105", 4'b1111, 1'b0, 2'd1);
    goto(120); chk_out("rl120", 4'b1111, 1'b0, 2'd1);
    goto(121); chk_out("rl121", 4'b1110, 1'b0, 2'd1);
    goto(168); chk_out("rl168", 4'b1000, 1'b0, 2'd1);
    goto(169); chk_out("rl169", 4'b0000, 1'b1, 2'd2);

    sif.lock = 1'b0;
    goto(172); chk_out("ll172", 4'b1111, 1'b0, 2'd0);
    sif.lock = 1'b1;
    goto(175); chk_out("rl175", 4'b1111, 1'b0, 2'd1);
    goto(210); chk_out("pre_soft", 4'b1100, 1'b0, 2'd1);
    sif.soft_rst_req = 1'b1;
    goto(211); sif.soft_rst_req = 1'b0;
    chk_out("soft211", 4'b1111, 1'b0, 2'd3);
    goto(213); sif.soft_rst_req = 1'b1;
    goto(214); sif.soft_rst_req = 1'b0;
    goto(218); chk_out("soft218", 4'b1111, 1'b0, 2'd3);
    goto(219); chk_out("soft219", 4'b1111, 1'b0, 2'd0);
    goto(220); chk_out("soft220", 4'b1111, 1'b0, 2'd1);
    goto(235); chk_out("soft235", 4'b1111, 1'b0, 2'd1);
    goto(236); chk_out("soft236", 4'b1110, 1'b0, 2'd1);
    goto(284); chk_out("run284",  4'b0000, 1'b1, 2'd2);

    goto(290); sif.lock = 1'b0;
    goto(292); chk_out("both292", 4'b0000, 1'b1, 2'd2);
    sif.soft_rst_req = 1'b1;
    goto(293); sif.soft_rst_req = 1'b0;
    chk_out("both293", 4'b1111, 1'b0, 2'd0);

    sif.lock = 1'b1;
    goto(296); chk_out("ar296", 4'b1111, 1'b0, 2'd1);
    goto(320); chk_out("ar320", 4'b1110, 1'b0, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async", 4'b1111, 1'b0, 2'd0);
    #10;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
